// File: rtl/rfsw_pkg.sv
// rfsw_pkg: shared mode encodings and pattern-length normalisation for the RF switch controller
package rfsw_pkg;
  localparam logic [1:0] RFSW_OFF     = 2'd0;
  localparam logic [1:0] RFSW_TOGGLE  = 2'd1;
  localparam logic [1:0] RFSW_PATTERN = 2'd2;
  localparam logic [1:0] RFSW_ONESHOT = 2'd3;
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction
endpackage

// File: rtl/rfsw_multi_ctrl_if.sv
// rfsw_multi_ctrl_if: control/strobe inputs and switch-enable outputs of the multi-channel RF switch controller
interface rfsw_multi_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int PAT_W = 32,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(PAT_W + 1);
  logic              en;
  logic [1:0]        mode;
  logic [N_CH-1:0]   pulse;
  logic              pat_load;
  logic [PAT_W-1:0]  pat_data;
  logic [LW-1:0]     pat_len;
  logic [CNT_W-1:0]  hold_cyc;
  logic [N_CH-1:0]   SWEN;
  logic [N_CH-1:0]   pat_wrap;
  logic [N_CH-1:0]   busy;
  modport master (output en, mode, pulse, pat_load, pat_data, pat_len, hold_cyc,
                  input SWEN, pat_wrap, busy);
  modport slave (input en, mode, pulse, pat_load, pat_data, pat_len, hold_cyc,
                 output SWEN, pat_wrap, busy);
endinterface

// File: rtl/rfsw_channel.sv
// rfsw_channel: one switch channel turning strobes into an enable level per the shared mode
module rfsw_channel
  import rfsw_pkg::*;
#(
  parameter int PAT_W = 32,
  parameter int CNT_W = 16,
  localparam int LW = $clog2(PAT_W + 1),
  localparam int IW = $clog2(PAT_W)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [1:0]       mode_q,
  input  logic             pulse,
  input  logic [PAT_W-1:0] pat,
  input  logic [LW-1:0]    len,
  input  logic [CNT_W-1:0] hold_cyc,
  output logic             swen,
  output logic             pat_wrap,
  output logic             busy
);
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] cnt;
  logic             last;
  assign last = LW'(idx) == len - LW'(1);
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      swen     <= 1'b0;
      pat_wrap <= 1'b0;
      busy     <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
    end else if (clr) begin
      swen     <= 1'b0;
      pat_wrap <= 1'b0;
      busy     <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
    end else begin
      pat_wrap <= 1'b0;
      if (load) idx <= '0;
      case (mode_q)
        RFSW_TOGGLE: if (pulse) swen <= !swen;
        RFSW_PATTERN: if (pulse && !load) begin
          swen     <= pat[idx];
          idx      <= last ? '0 : idx + 1'b1;
          pat_wrap <= last;
        end
        RFSW_ONESHOT: if (pulse && hold_cyc != '0) begin
          swen <= 1'b1;
          busy <= 1'b1;
          cnt  <= hold_cyc - 1'b1;
        end else if (busy) begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            swen <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/rfsw_multi_ctrl.sv
// rfsw_multi_ctrl: N-channel RF switch enable controller; owns mode, pattern registers and clear/load decode
module rfsw_multi_ctrl
  import rfsw_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PAT_W = 32,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic rst,
  rfsw_multi_ctrl_if.slave bus
);
  localparam int LW = $clog2(PAT_W + 1);
  logic [1:0]       mode_q;
  logic [PAT_W-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic             clr, load;
  logic [N_CH-1:0]  swen_w, wrap_w, busy_w;
  assign clr  = !bus.en || bus.mode != mode_q;
  assign load = !clr && bus.pat_load;
  // mode_q follows mode every cycle so a change made while disabled is absorbed before en returns
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mode_q <= RFSW_OFF;
      pat_q  <= '0;
      len_q  <= LW'(PAT_W);
    end else begin
      mode_q <= bus.mode;
      if (load) begin
        pat_q <= bus.pat_data;
        len_q <= LW'(norm_len(32'(bus.pat_len), PAT_W));
      end
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rfsw_channel #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_ch (
      .CLK      (CLK),
      .rst      (rst),
      .clr      (clr),
      .load     (load),
      .mode_q   (mode_q),
      .pulse    (bus.pulse[i]),
      .pat      (pat_q),
      .len      (len_q),
      .hold_cyc (bus.hold_cyc),
      .swen     (swen_w[i]),
      .pat_wrap (wrap_w[i]),
      .busy     (busy_w[i])
    );
  end
  assign bus.SWEN     = swen_w;
  assign bus.pat_wrap = wrap_w;
  assign bus.busy     = busy_w;
endmodule

// File: doc/rfsw_multi_ctrl.md
# rfsw_multi_ctrl

Parametrised multi-channel RF switch enable controller; successor to the single-channel pulse-toggle switch driver. Each of `N_CH` channels turns a strobe on `pulse[i]` into its `SWEN[i]` level. A global mode selects one of four behaviours: off, toggle, pattern sequencing from a shared loadable bit pattern, or retriggerable one-shot of programmable width. It sits between the backscatter timing/strobe logic and the RF switch pads.

## Interface
Parameters:
- `N_CH`, 4: number of switch channels (≥1)
- `PAT_W`, 32: pattern register width in bits (≥2)
- `CNT_W`, 16: one-shot hold counter width

Ports:
- `CLK`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  global enable; low forces all channels idle
- `mode`  in  2  0 OFF, 1 TOGGLE, 2 PATTERN, 3 ONESHOT
- `pulse`  in  N_CH  per-channel single-cycle strobe (a level is treated as one strobe per cycle)
- `pat_load`  in  1  latch `pat_data`/`pat_len`
- `pat_data`  in  PAT_W  pattern; bit 0 emitted first
- `pat_len`  in  $clog2(PAT_W+1)  active pattern length; 0 or >PAT_W means PAT_W
- `hold_cyc`  in  CNT_W  one-shot high time in cycles
- `SWEN`  out  N_CH  switch enable per channel
- `pat_wrap`  out  N_CH  1-cycle flag: channel index wrapped to 0
- `busy`  out  N_CH  channel in active one-shot

## Operation
- Reset (async, `rst`=1): `SWEN`=0, `pat_wrap`=0, `busy`=0, all indices/counters 0, pattern reg 0, effective length PAT_W, registered mode `mode_q`=OFF.
- Channel clear: SWEN=0, idx=0, cnt=0, busy=0. Triggered when `en`=0, or when `mode`≠`mode_q`. On a mode change, `mode_q` updates and every channel is cleared in that same cycle. Pulses in that cycle are dropped.
- OFF: SWEN held 0; pulses ignored.
- TOGGLE: each pulse inverts SWEN[i].
- PATTERN: on pulse, SWEN[i] ← pat[idx_i].
  - If idx_i = len−1: idx_i ← 0 and pat_wrap[i]=1 next cycle.
  - Otherwise idx_i ← idx_i+1.
  - Between pulses SWEN holds its value.
- ONESHOT: on pulse with `hold_cyc`≠0: SWEN[i]←1, busy[i]←1, cnt←hold_cyc−1.
  - While busy with no pulse: cnt>0 decrements; cnt=0 clears SWEN and busy.
  - Pulse while busy reloads the counter (retrigger; high time extends from the new pulse).
  - `hold_cyc`=0: pulse ignored.
- `pat_load` (any mode, en high): latch pattern and length; all idx ← 0.
  - Pulses in the load cycle are dropped in PATTERN mode only.
  - SWEN is unchanged.
- Priority, highest first: rst > en low > mode change > pat_load > pulse.

## Timing
- Pulse-to-SWEN latency: 1 cycle, registered output, no combinational path from input to output.
- `pat_wrap` asserts the cycle after the wrapping pulse, for exactly 1 cycle.
- ONESHOT with hold_cyc=H: SWEN high for exactly H cycles, starting the cycle after the pulse.
- `busy[i]` equals SWEN[i] in ONESHOT and is 0 in other modes.
- `en` falling: SWEN=0 on the next edge. `en` rising: first accepted pulse is the one sampled in the same cycle that en=1.
- pat_len=1: every pulse emits pat[0] and flags pat_wrap.
- Mid-operation `rst`: outputs go to 0 immediately (async), independent of CLK.

## Structure
- Shared package `rfsw_pkg`:
  - mode localparams `RFSW_OFF`/`RFSW_TOGGLE`/`RFSW_PATTERN`/`RFSW_ONESHOT` (2-bit)
  - length normalisation function (0/overflow → PAT_W)
- Sub-module `rfsw_channel`, generated N_CH times:
  - inputs: the shared pattern register, normalised length, `mode_q`, and clear/load strobes
  - holds idx, cnt, SWEN, pat_wrap, busy
- Top holds `mode_q`, the pattern/length registers, and the clear/priority decode.

## Test plan
- Reset then TOGGLE, N_CH=4, pulse[2] on cycles 5, 9 → SWEN[2] 0→1 at cycle 6, 1→0 at cycle 10; other channels stay 0.
- PATTERN: load 0b1011 with pat_len=4, 5 pulses on ch0 → SWEN 1,1,0,1,1; pat_wrap high the cycle after the 4th pulse only.
- ONESHOT: hold_cyc=3, pulse at t → SWEN high t+1..t+3, busy matches. Second pulse at t+2 → SWEN high through t+5.
- Edge cases: hold_cyc=0 pulse → no change; pat_len=0 → 32-pulse wrap; pat_load coincident with pulse in PATTERN → pulse dropped, idx=0.
- Mode change TOGGLE→PATTERN with SWEN=1 → cleared to 0 next edge, coincident pulse dropped. en low for 1 cycle mid-oneshot → SWEN 0, busy 0.
- Assert `rst` asynchronously mid-pattern between edges → SWEN 0 before next CLK edge; after release, idx restarts at 0.
